// File: rtl/psram_arb_pkg.sv
// Shared types for the psram port arbiter: FSM states, latched op kind and
// the read data substituted when the watchdog (PSRAM_ARB_TIMEOUT_EN) fires.
package psram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  typedef enum logic {OP_RD, OP_WR} arb_op_t;

  localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request strictly after ptr,
// wrapping, so the pointer's own index has the lowest priority.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [IDX_BITS-1:0] grant,
  output logic                valid
);

  logic [IDX_BITS-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_BITS'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_port_arbiter.sv
// Round-robin sharing of one psram controller port between NUM_REQ requesters,
// one transaction in flight. Optional WAIT watchdog: define PSRAM_ARB_TIMEOUT_EN.
module psram_port_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_BITS      = 23,
  parameter int unsigned DATA_BITS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_rd,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [DATA_BITS-1:0]           req_rdata,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [ADDR_BITS-1:0]           rd_address,
  output logic                           rd_en,
  input  logic                           rd_ack,
  input  logic [DATA_BITS-1:0]           rd_data,
  output logic [ADDR_BITS-1:0]           wr_address,
  output logic                           wr_en,
  output logic [DATA_BITS-1:0]           wr_data,
  input  logic                           wr_ack
);

  localparam int unsigned IDX_BITS = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("psram_port_arbiter: parameter out of range");
  end

  arb_state_t             state, state_d;
  arb_op_t                op_q, pick_op;
  logic [IDX_BITS-1:0]    ptr_q, grant_q, pick;
  logic                   pick_valid;
  logic [ADDR_BITS-1:0]   addr_q, pick_addr;
  logic [DATA_BITS-1:0]   wdata_q, pick_wdata;
  logic                   op_ack;
  logic                   wd_expired;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_rr (
    .req   (req_rd | req_wr),
    .ptr   (ptr_q),
    .grant (pick),
    .valid (pick_valid)
  );

  // Write wins when a port raises both request kinds.
  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_op    = OP_RD;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_BITS'(i) == pick) begin
        pick_addr  = req_addr[i*ADDR_BITS +: ADDR_BITS];
        pick_wdata = req_wdata[i*DATA_BITS +: DATA_BITS];
        pick_op    = req_wr[i] ? OP_WR : OP_RD;
      end
    end
  end

  assign op_ack = (op_q == OP_RD) ? rd_ack : wr_ack;

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES);

  logic [CNT_BITS-1:0] wd_cnt;
  logic                timeout_q;

  assign wd_expired  = (wd_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ISSUE) wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (state == WAIT && !op_ack && wd_expired) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (op_ack || wd_expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr_q     <= IDX_BITS'(NUM_REQ - 1);
      grant_q   <= '0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_rdata <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (pick_valid) begin
          grant_q <= pick;
          op_q    <= pick_op;
          addr_q  <= pick_addr;
          wdata_q <= pick_wdata;
        end
        WAIT: if (op_q == OP_RD) begin
          if (rd_ack) req_rdata <= rd_data;
          else if (wd_expired) req_rdata <= DATA_BITS'(TIMEOUT_RDATA);
        end
        DONE:    ptr_q <= grant_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ack = '0;
    if (state == DONE) req_ack[grant_q] = 1'b1;
  end

  assign busy       = (state != IDLE);
  assign rd_en      = (state == ISSUE) && (op_q == OP_RD);
  assign wr_en      = (state == ISSUE) && (op_q == OP_WR);
  assign rd_address = addr_q;
  assign wr_address = addr_q;
  assign wr_data    = wdata_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Self-checking bench for psram_port_arbiter: directed steps plus randomized
// traffic against a round-robin / memory reference model and a psram responder.
module tb_psram_port_arbiter;

  localparam int N  = 3;
  localparam int AB = 23;
  localparam int DB = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_rd, req_wr, req_ack;
  logic [N*AB-1:0] req_addr;
  logic [N*DB-1:0] req_wdata;
  logic [DB-1:0]   req_rdata, rd_data, wr_data;
  logic            busy, timeout_err, rd_en, wr_en, rd_ack, wr_ack;
  logic [AB-1:0]   rd_address, wr_address;
  logic            rd_ack_m = 1'b0, wr_ack_m = 1'b0, poke_rd = 1'b0, poke_wr = 1'b0;

  assign rd_ack = rd_ack_m | poke_rd;
  assign wr_ack = wr_ack_m | poke_wr;

  always #5 clk = ~clk;

  psram_port_arbiter #(
    .NUM_REQ(N), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .req_rdata(req_rdata), .busy(busy), .timeout_err(timeout_err),
    .rd_address(rd_address), .rd_en(rd_en), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  // ---------------- psram responder (environment) ----------------
  int            lat = 3;
  bit            withhold = 0, stray = 0, pend = 0, pkind = 0;
  int            left = 0, n_rd = 0, n_wr = 0;
  logic [AB-1:0] paddr, log_addr;
  logic [DB-1:0] log_wdata;
  logic [DB-1:0] mem [logic [AB-1:0]];

  function automatic logic [DB-1:0] dflt(input logic [AB-1:0] a);
    return a[DB-1:0] ^ 16'hC3C3;
  endfunction

  always @(posedge clk) begin
    rd_ack_m <= 1'b0;
    wr_ack_m <= 1'b0;
    if (!reset_n) pend = 0;
    else if (rd_en || wr_en) begin
      if (rd_en) n_rd++;
      if (wr_en) begin n_wr++; mem[wr_address] = wr_data; log_wdata = wr_data; end
      log_addr = wr_en ? wr_address : rd_address;
      paddr = rd_address; pkind = wr_en; left = lat; pend = !withhold;
      if (stray) begin
        if (wr_en) rd_ack_m <= 1'b1; else wr_ack_m <= 1'b1;
      end
    end else if (pend) begin
      left--;
      if (left <= 0) begin
        pend = 0;
        if (pkind) wr_ack_m <= 1'b1;
        else begin
          rd_ack_m <= 1'b1;
          rd_data  <= mem.exists(paddr) ? mem[paddr] : dflt(paddr);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  int            tests = 0, fails = 0;
  int            mptr = N - 1;
  bit            act[N], rdb[N], wrb[N];
  logic [AB-1:0] a_arr[N];
  logic [DB-1:0] d_arr[N];
  logic [DB-1:0] ref_mem [logic [AB-1:0]];
  logic [DB-1:0] last_rdata = '0;

  function automatic logic [DB-1:0] ref_rd(input logic [AB-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic int expect_grant();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (act[j]) return j;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_rd[i] = act[i] && rdb[i];
      req_wr[i] = act[i] && wrb[i];
      req_addr[i*AB +: AB]  = a_arr[i];
      req_wdata[i*DB +: DB] = d_arr[i];
    end
  endtask

  task automatic newreq(input int i, input bit rd, input bit wr,
                        input logic [AB-1:0] a, input logic [DB-1:0] d);
    rdb[i] = rd; wrb[i] = wr; a_arr[i] = a; d_arr[i] = d; act[i] = 1;
  endtask

  task automatic rand_req(input int i);
    int r;
    r = $urandom_range(0, 2);
    newreq(i, r != 1, r != 0, AB'(23'h200 + $urandom_range(0, 15)), DB'($urandom));
  endtask

  // Waits for the next completion and checks it against the model; e_in<0 lets the model pick.
  task automatic serve(input string tag, input int e_in, output int n);
    int e, g, nr0, nw0;
    bit got;
    e = (e_in >= 0) ? e_in : expect_grant();
    nr0 = n_rd; nw0 = n_wr; got = 0; n = 0; g = -1;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      got = (req_ack != '0);
    end
    chk({tag, ":ack_seen"}, 32'(got), 1);
    if (got) begin
      for (int k = 0; k < N; k++) if (req_ack[k]) g = k;
      chk({tag, ":onehot"}, $countones(req_ack), 1);
      chk({tag, ":grant"}, g, e);
      chk({tag, ":n_rd"}, n_rd - nr0, wrb[e] ? 0 : 1);
      chk({tag, ":n_wr"}, n_wr - nw0, wrb[e] ? 1 : 0);
      chk({tag, ":addr"}, 32'(log_addr), 32'(a_arr[e]));
      if (wrb[e]) begin
        chk({tag, ":wdata"}, 32'(log_wdata), 32'(d_arr[e]));
        ref_mem[a_arr[e]] = d_arr[e];
      end else begin
        last_rdata = ref_rd(a_arr[e]);
        chk({tag, ":rdata"}, 32'(req_rdata), 32'(last_rdata));
      end
    end
    act[e] = 0;
    mptr = e;
    drive();
    @(negedge clk);
    chk({tag, ":ack_pulse"}, 32'(req_ack), 0);
    chk({tag, ":idle_busy"}, 32'(busy), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) act[i] = 0;
    drive();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mptr = N - 1;
    last_rdata = '0;
  endtask

  initial begin
    int  n, m;
    bit  got;
    reset_n = 1'b0; rd_data = '0;
    for (int i = 0; i < N; i++) begin act[i] = 0; rdb[i] = 0; wrb[i] = 0; a_arr[i] = '0; d_arr[i] = '0; end
    drive();
    repeat (3) @(negedge clk);
    chk("rst:req_ack", 32'(req_ack), 0);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:strobes", {30'd0, rd_en, wr_en}, 0);
    chk("rst:rd_address", 32'(rd_address), 0);
    chk("rst:wr_address", 32'(wr_address), 0);
    chk("rst:wr_data", 32'(wr_data), 0);
    chk("rst:req_rdata", 32'(req_rdata), 0);
    chk("rst:timeout_err", 32'(timeout_err), 0);
    reset_n = 1'b1;

    // single read, psram latency 5
    mem[23'h000100] = 16'h1234; ref_mem[23'h000100] = 16'h1234;
    lat = 5;
    newreq(0, 1, 0, 23'h000100, '0); drive();
    serve("t1", -1, n);
    chk("t1:latency", n, 8);
    chk("t1:rdata_const", 32'(req_rdata), 32'h1234);

    // single write, then read it back; minimum latency with psram latency 1
    lat = 1;
    newreq(1, 0, 1, 23'h00ABCD, 16'h55AA); drive();
    serve("t2", -1, n);
    chk("t2:latency", n, 4);
    newreq(0, 1, 0, 23'h00ABCD, '0); drive();
    serve("t2rb", -1, n);
    chk("t2rb:rdata_const", 32'(req_rdata), 32'h55AA);

    // acks while idle are ignored
    poke_rd = 1'b1; poke_wr = 1'b1; rd_data = 16'hBEEF;
    @(negedge clk);
    poke_rd = 1'b0; poke_wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack:busy", 32'(busy), 0);
      chk("idle_ack:req_ack", 32'(req_ack), 0);
    end
    chk("idle_ack:rdata", 32'(req_rdata), 32'(last_rdata));

    // read and write on one port: write wins
    lat = 2;
    newreq(2, 1, 1, 23'h000777, 16'hA5C3); drive();
    serve("t4", -1, n);

    // request withdrawn while in flight still completes
    newreq(1, 1, 0, 23'h000042, '0); drive();
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    chk("drop:busy", 32'(busy), 1);
    act[1] = 0; drive();
    serve("drop", 1, n);

    // reset asserted in WAIT
    withhold = 1;
    newreq(0, 1, 0, 23'h000100, '0); drive();
    repeat (10) @(negedge clk);
    chk("t5:busy_wait", 32'(busy), 1);
    chk("t5:no_ack", 32'(req_ack), 0);
    reset_n = 1'b0;
    #1;
    chk("t5:busy_rst", 32'(busy), 0);
    chk("t5:strobes_rst", {30'd0, rd_en, wr_en}, 0);
    chk("t5:addr_rst", 32'(rd_address), 0);
    chk("t5:rdata_rst", 32'(req_rdata), 0);
    chk("t5:timeout_rst", 32'(timeout_err), 0);
    withhold = 0;
    for (int i = 0; i < N; i++) act[i] = 0;
    drive();
    repeat (2) @(negedge clk);
    reset_n = 1'b1; mptr = N - 1; last_rdata = '0;
    @(negedge clk);
    chk("t5:busy_after", 32'(busy), 0);

    // fairness: all ports requesting continuously, grants 0,1,2,...
    lat = 1;
    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < N; i++) if (!act[i]) rand_req(i);
      drive();
      serve("t3", t % N, n);
    end
    for (int i = 0; i < N; i++) act[i] = 0;
    drive();

    // randomized traffic with stray acks of the wrong kind
    for (int t = 0; t < 24; t++) begin
      bit any;
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 1) == 1) rand_req(i);
        any |= act[i];
      end
      if (!any) rand_req($urandom_range(0, N - 1));
      lat   = $urandom_range(1, 6);
      stray = ($urandom_range(0, 2) == 0);
      drive();
      serve("rnd", -1, n);
    end
    stray = 0;
    for (int i = 0; i < N; i++) act[i] = 0;
    drive();

`ifdef PSRAM_ARB_TIMEOUT_EN
    pulse_reset();
    withhold = 1;
    newreq(1, 1, 0, 23'h000300, '0); drive();
    n = 0; got = 0;
    while (!got && n < 20) begin @(negedge clk); n++; got = rd_en; end
    chk("t6:rd_en_seen", 32'(got), 1);
    m = 0; got = 0;
    while (!got && m < 200) begin @(negedge clk); m++; got = (req_ack != '0); end
    chk("t6:wait_cycles", m, 65);
    chk("t6:ack_port", 32'(req_ack), 32'b010);
    chk("t6:rdata", 32'(req_rdata), 32'hDEAD);
    chk("t6:err_set", 32'(timeout_err), 1);
    act[1] = 0; drive(); withhold = 0;
    repeat (5) @(negedge clk);
    chk("t6:err_sticky", 32'(timeout_err), 1);
    pulse_reset();
    chk("t6:err_cleared", 32'(timeout_err), 0);
`else
    chk("cfg:timeout_err_tied", 32'(timeout_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
